// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide unit for HI/LO.
// Shift-add multiply, restoring divide, sign fixup in a final state.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SIGN
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mc_q, mc_d;
  logic [WIDTH-1:0] p_hi_q, p_hi_d;
  logic [WIDTH-1:0] p_lo_q, p_lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;

  // Next-state, datapath iteration and result fixup
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_d     = mc_q;
    p_hi_d   = p_hi_q;
    p_lo_d   = p_lo_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;

    a_neg = op[0] & a[WIDTH-1];
    b_neg = op[0] & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;

    sum = {1'b0, p_hi_q}
        + (p_lo_q[0] ? {1'b0, mc_q} : '0);
    shifted = {p_hi_q, p_lo_q[WIDTH-1]};
    diff = shifted - {1'b0, mc_q};

    prod = {p_hi_q, p_lo_q};
    prod_neg = -prod;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          cnt_d    = '0;
          mc_d     = b_mag;
          p_hi_d   = '0;
          p_lo_d   = a_mag;
          is_div_d = op[1];
          neg_q_d  = a_neg ^ b_neg;
          neg_r_d  = a_neg;
          dz_d     = op[1] & (b == '0);
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          if (!diff[WIDTH]) begin
            p_hi_d = diff[WIDTH-1:0];
            p_lo_d = {p_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            p_hi_d = shifted[WIDTH-1:0];
            p_lo_d = {p_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          p_hi_d = sum[WIDTH:1];
          p_lo_d = {sum[0], p_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        dbz_d   = dz_q;
        if (is_div_q) begin
          if (dz_q) begin
            lo_d = '1;
          end else begin
            lo_d = neg_q_q ? -p_lo_q : p_lo_q;
          end
          hi_d = neg_r_q ? -p_hi_q : p_hi_q;
        end else begin
          {hi_d, lo_d} = neg_q_q ? prod_neg : prod;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mc_q     <= '0;
      p_hi_q   <= '0;
      p_lo_q   <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mc_q     <= mc_d;
      p_hi_q   <= p_hi_d;
      p_lo_q   <= p_lo_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
